// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window on dmem writes, TX FIFO,
// registered serial output with a programmable per-bit divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16,
  parameter int          DIV_WIDTH  = 16
) (
  input  logic        clkin,
  input  logic        rst_in,
  input  logic        wr_en_in,
  input  logic [31:0] wr_addr_in,
  input  logic [31:0] wr_data_in,
  input  logic [31:0] rd_addr_in,
  output logic [31:0] rd_data_out,
  output logic        rd_hit_out,
  output logic        tx_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [1:0]           state;
  logic [DIV_WIDTH-1:0] baud_cnt, div, div_m1;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count;
  logic                 overflow, enable;
  logic                 wr_hit, push_req, push, pop, full, empty;
  logic [1:0]           wr_off;
  logic [31:0]          status;
  logic                 unused_ok;

  assign wr_hit   = wr_en_in && (wr_addr_in[31:4] == BASE_ADDR[31:4]);
  assign wr_off   = wr_addr_in[3:2];
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_hit && (wr_off == 2'd0);
  // Fullness is judged before any same-cycle pop, so a push on full is always dropped.
  assign push     = push_req && !full;
  assign pop      = (state == S_IDLE) && enable && !empty;
  assign div_m1   = div - DIV_WIDTH'(1);
  assign unused_ok = ^{wr_addr_in[1:0], rd_addr_in[1:0], wr_data_in};

  always_ff @(posedge clkin) begin
    if (push) mem[wptr] <= wr_data_in[7:0];
  end

  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
      div      <= DIV_WIDTH'(CLK_DIV);
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr_hit && wr_off == 2'd1 && wr_data_in[3])
        overflow <= 1'b0;
      if (wr_hit && wr_off == 2'd2) enable <= wr_data_in[0];
      if (wr_hit && wr_off == 2'd3)
        div <= (wr_data_in[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : wr_data_in[DIV_WIDTH-1:0];
    end
  end

  // Divisor is sampled only at reloads, so a mid-frame DIV write applies from the next bit.
  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          shreg    <= mem[rptr];
          baud_cnt <= div_m1;
          tx_out   <= 1'b0;
          state    <= S_START;
        end
        S_START: if (baud_cnt == '0) begin
          baud_cnt <= div_m1;
          bit_idx  <= '0;
          tx_out   <= shreg[0];
          state    <= S_DATA;
        end else baud_cnt <= baud_cnt - 1'b1;
        S_DATA: if (baud_cnt == '0) begin
          baud_cnt <= div_m1;
          if (bit_idx == 3'd7) begin
            tx_out <= 1'b1;
            state  <= S_STOP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg >> 1;
            tx_out  <= shreg[1];
          end
        end else baud_cnt <= baud_cnt - 1'b1;
        S_STOP: if (baud_cnt == '0) state <= S_IDLE;
                else baud_cnt <= baud_cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    status               = '0;
    status[0]            = full;
    status[1]            = empty;
    status[2]            = (state != S_IDLE);
    status[3]            = overflow;
    status[8 +: AW+1]    = count;
  end

  assign rd_hit_out = (rd_addr_in[31:4] == BASE_ADDR[31:4]);

  always_comb begin
    rd_data_out = '0;
    if (rd_hit_out) begin
      case (rd_addr_in[3:2])
        2'd1:    rd_data_out = status;
        2'd2:    rd_data_out = {31'b0, enable};
        2'd3:    rd_data_out = 32'(div);
        default: rd_data_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vector table plus frame-level sequences.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE, A_ST = BASE + 32'h4, A_CT = BASE + 32'h8, A_DV = BASE + 32'hC;

  logic        clkin = 1'b0, rst_in = 1'b1, wr_en_in = 1'b0;
  logic [31:0] wr_addr_in = '0, wr_data_in = '0, rd_addr_in = '0;
  logic [31:0] rd_data_out;
  logic        rd_hit_out, tx_out;
  int          n_cmp = 0, n_bad = 0, cyc = 0;

  mmio_uart_tx dut (
    .clkin(clkin), .rst_in(rst_in), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
    .rd_hit_out(rd_hit_out), .tx_out(tx_out)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  typedef struct {
    bit          do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clkin);
    wr_en_in = 1'b1; wr_addr_in = a; wr_data_in = d;
    @(negedge clkin);
    wr_en_in = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_addr_in = a;
    #1;
    d = rd_data_out;
  endtask

  // Wait for a start bit, then sample every cycle of a 10*div frame.
  task automatic rx_frame(input int div, output logic [7:0] b, output int t_start,
                          output int busy_n, output logic [31:0] st0, output bit ok);
    logic [9:0] fr;
    fr = '1; b = '0; t_start = -1; busy_n = 0; st0 = '0; ok = 1'b0;
    rd_addr_in = A_ST;
    for (int i = 0; i < 20*div + 100; i++) begin
      @(negedge clkin);
      if (tx_out === 1'b0) break;
    end
    if (tx_out !== 1'b0) return;
    ok = 1'b1; t_start = cyc; st0 = rd_data_out;
    for (int k = 0; k < 10*div; k++) begin
      if (k > 0) @(negedge clkin);
      if (k % div == 0) fr[k/div] = tx_out;
      else if (tx_out !== fr[k/div]) ok = 1'b0;
      busy_n += int'(rd_data_out[2]);
    end
    if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ok = 1'b0;
    b = fr[8:1];
  endtask

  function automatic logic exp_mid(input int k, input logic [7:0] b);
    if (k < 2)  return 1'b0;
    if (k < 4)  return b[0];
    if (k < 60) return b[1 + (k-4)/8];
    return 1'b1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          t0, t1, t2, bz, c0, lows, bad;
    logic [31:0] s0, s1, s2;
    bit          ok, ok1, ok2;
    logic [7:0]  b1, b2;

    tbl[0]  = '{0, 32'h0, 32'h0,         A_ST,               32'h2,   1'b1};
    tbl[1]  = '{0, 32'h0, 32'h0,         A_CT,               32'h1,   1'b1};
    tbl[2]  = '{0, 32'h0, 32'h0,         A_DV,               32'd868, 1'b1};
    tbl[3]  = '{0, 32'h0, 32'h0,         A_TX,               32'h0,   1'b1};
    tbl[4]  = '{1, A_DV,  32'h0,         A_DV,               32'h1,   1'b1};
    tbl[5]  = '{1, A_DV,  32'hABCD_0005, A_DV,               32'h5,   1'b1};
    tbl[6]  = '{1, A_CT,  32'h0,         A_CT,               32'h0,   1'b1};
    tbl[7]  = '{1, A_CT,  32'hFFFF_FFFE, A_CT,               32'h0,   1'b1};
    tbl[8]  = '{1, A_CT,  32'h3,         A_CT,               32'h1,   1'b1};
    tbl[9]  = '{1, A_ST,  32'hFFFF_FFFF, A_ST,               32'h2,   1'b1};
    tbl[10] = '{0, 32'h0, 32'h0,         BASE + 32'h10,      32'h0,   1'b0};
    tbl[11] = '{0, 32'h0, 32'h0,         BASE + 32'h7,       32'h2,   1'b1};

    repeat (3) @(negedge clkin);
    check("reset_tx", {31'b0, tx_out}, 32'h1);
    rst_in = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_wr) mmio_write(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, d);
      check($sformatf("vec%0d_data", i), d, tbl[i].exp_data);
      check($sformatf("vec%0d_hit", i), {31'b0, rd_hit_out}, {31'b0, tbl[i].exp_hit});
    end

    // DIV=4, single 0x55 frame
    mmio_write(A_DV, 32'd4);
    rd_addr_in = A_ST;
    mmio_write(A_TX, 32'h55);
    c0 = cyc;
    rx_frame(4, b, t0, bz, s0, ok);
    check("f55_ok_byte", {23'b0, ok, b}, {23'b0, 1'b1, 8'h55});
    check("f55_latency", t0 - c0, 32'd1);
    check("f55_busy_cycles", bz, 32'd40);
    @(negedge clkin);
    check("f55_after", {30'b0, rd_data_out[2], tx_out}, 32'h1);

    // DIV=2, three bytes back-to-back
    mmio_write(A_DV, 32'd2);
    fork
      begin
        mmio_write(A_TX, 32'hA1);
        mmio_write(A_TX, 32'h3C);
        mmio_write(A_TX, 32'hFF);
      end
      begin
        rx_frame(2, b,  t0, bz, s0, ok);
        rx_frame(2, b1, t1, bz, s1, ok1);
        rx_frame(2, b2, t2, bz, s2, ok2);
      end
    join
    check("b2b_f0", {23'b0, ok, b},   {23'b0, 1'b1, 8'hA1});
    check("b2b_f1", {23'b0, ok1, b1}, {23'b0, 1'b1, 8'h3C});
    check("b2b_f2", {23'b0, ok2, b2}, {23'b0, 1'b1, 8'hFF});
    check("b2b_gap01", t1 - t0, 32'd21);
    check("b2b_gap12", t2 - t1, 32'd21);
    check("b2b_st1", s1, 32'h104);
    check("b2b_st2", s2, 32'h6);

    // FIFO fill with enable low, overflow, clear, drain
    mmio_write(A_CT, 32'h0);
    mmio_write(A_DV, 32'd100);
    for (int i = 0; i < 17; i++) mmio_write(A_TX, 32'h40 + i);
    rd(A_ST, d);
    check("ovf_status", d, 32'h1009);
    mmio_write(A_ST, 32'h8);
    rd(A_ST, d);
    check("ovf_cleared", d, 32'h1001);
    mmio_write(A_CT, 32'h1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rx_frame(100, b, t0, bz, s0, ok);
      if (!ok || b !== 8'(8'h40 + i)) begin
        bad++;
        $display("FAIL drain_frame%0d: ok=%0d got 0x%02h expected 0x%02h", i, ok, b, 8'(8'h40 + i));
      end
    end
    check("drain_bad_frames", bad, 32'd0);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clkin);
      if (tx_out !== 1'b1) lows++;
    end
    check("drain_no_17th", lows, 32'd0);
    rd(A_ST, d);
    check("drain_status", d, 32'h2);

    // DIV=0 stored as 1, ten-cycle frame
    mmio_write(A_DV, 32'h0);
    rd(A_DV, d);
    check("div0_reads1", d, 32'h1);
    mmio_write(A_TX, 32'h96);
    rx_frame(1, b, t0, bz, s0, ok);
    check("div1_frame", {23'b0, ok, b}, {23'b0, 1'b1, 8'h96});
    check("div1_busy", bz, 32'd10);
    @(negedge clkin);
    check("div1_idle", {31'b0, rd_data_out[2]}, 32'h0);

    // DIV change mid-frame: bit0 keeps 2 cycles, later bits take 8
    mmio_write(A_DV, 32'd2);
    mmio_write(A_TX, 32'hA5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (tx_out === 1'b0) break;
    end
    bad = 0;
    for (int k = 0; k < 72; k++) begin
      if (k > 0) @(negedge clkin);
      if (k == 2) wr_en_in = 1'b0;
      if (tx_out !== exp_mid(k, 8'hA5)) bad++;
      if (k == 1) begin
        wr_en_in = 1'b1; wr_addr_in = A_DV; wr_data_in = 32'd8;
      end
    end
    check("middiv_bad_cycles", bad, 32'd0);

    // Reset mid-DATA
    mmio_write(A_DV, 32'd4);
    mmio_write(A_TX, 32'h00);
    mmio_write(A_TX, 32'h33);
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (tx_out === 1'b0) break;
    end
    repeat (6) @(negedge clkin);
    check("pre_rst_tx_low", {31'b0, tx_out}, 32'h0);
    #2 rst_in = 1'b1;
    #1 check("rst_tx_immediate", {31'b0, tx_out}, 32'h1);
    @(negedge clkin);
    rst_in = 1'b0;
    rd(A_ST, d);
    check("post_rst_status", d, 32'h2);
    rd(A_DV, d);
    check("post_rst_div", d, 32'd868);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin);
      if (tx_out !== 1'b1) lows++;
    end
    check("post_rst_no_frame", lows, 32'd0);
    rd(BASE + 32'h100, d);
    check("miss_data", d, 32'h0);
    check("miss_hit", {31'b0, rd_hit_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's external data-memory interface, downstream of the core.
- Decodes dmem writes in its address window and queues bytes in a TX FIFO.
- Serialises bytes as 8N1 frames on tx_out.
- Status/control registers are readable through a combinational read port; the top-level read mux uses rd_hit_out to select it.

Parameters:
- BASE_ADDR, 32'h1000_0000, 16-byte aligned window base; bits [3:0] ignored.
- CLK_DIV, 868, reset value of the divisor register (clkin cycles per bit).
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DIV_WIDTH, 16, width of the divisor register and the baud counter.

Ports:
- clkin  input  1  system clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- wr_en_in  input  1  dmem write strobe, one write per asserted cycle.
- wr_addr_in  input  32  dmem write address.
- wr_data_in  input  32  dmem write data.
- rd_addr_in  input  32  dmem read address.
- rd_data_out  output  32  register read data, combinational from rd_addr_in.
- rd_hit_out  output  1  rd_addr_in[31:4] == BASE_ADDR[31:4].
- tx_out  output  1  serial line; idles high.

Behaviour:
- Address decode: hit = addr[31:4] == BASE_ADDR[31:4]; offset = addr[3:2].
- Register map:
  - 0x0 TXDATA: write pushes wr_data_in[7:0]; reads 0.
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 overflow (sticky), bits[16:8] FIFO count; other bits 0. Write: writing 1 to bit3 clears overflow; other bits ignored.
  - 0x8 CTRL: bit0 enable. Reads back zero-extended.
  - 0xC DIV: divisor[DIV_WIDTH-1:0]. A written 0 is stored as 1.
- rd_data_out is 0 when there is no hit.
- Reset values (asynchronous):
  - tx_out = 1, FIFO empty (count 0), overflow = 0.
  - enable = 1, DIV = CLK_DIV, state = IDLE, baud counter = 0.
  - rd_data_out/rd_hit_out follow rd_addr_in combinationally.
- FIFO push:
  - A TXDATA write when not full pushes at the clock edge; count increments.
  - A TXDATA write when full is dropped and sets overflow. Fullness is evaluated before any same-cycle pop, so a push on full is dropped even if a pop occurs.
  - A same-cycle push and pop on a non-full FIFO leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if enable && !empty, pop head into an 8-bit shift register, load baud counter with DIV-1, go to START. tx_out stays 1 during IDLE.
  - START: tx_out = 0 for DIV cycles.
  - DATA: 8 bits LSB first, each held DIV cycles; a 3-bit index counts 0..7.
  - STOP: tx_out = 1 for DIV cycles, then IDLE.
- Bit timing:
  - The baud counter decrements each cycle; the bit boundary is at counter == 0, which reloads DIV-1.
  - The DIV register value is sampled at each reload, so a DIV write mid-frame takes effect from the next bit.
- Frame timing:
  - First start bit appears on tx_out the cycle after the pop edge.
  - Frame is exactly 10*DIV cycles; STOP always returns to IDLE for one cycle.
  - Back-to-back frames therefore start 10*DIV+1 cycles apart.
- Clearing enable mid-frame finishes the current frame; no further pops occur.
- Asserting reset mid-frame forces tx_out high immediately and discards the FIFO contents and the partial frame.
- tx_out is driven from a register (no combinational glitches).

Test Plan:
- Reset, then read STATUS -> 0x0000_0002 (empty only); CTRL = 1; DIV = 868; tx_out = 1.
- DIV=4, write 0x55 to TXDATA -> next cycle tx_out: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy high for exactly 40 cycles.
- DIV=2, write 0xA1, 0x3C, 0xFF back-to-back -> three frames starting 21 cycles apart, decoded bytes match in order, empty set after the third pop.
- DIV=100, enable=0, write 17 bytes to a 16-deep FIFO -> count 16, full=1, overflow=1. Write 0x8 to STATUS -> overflow=0. Set enable=1 -> 16 frames transmitted, 17th byte absent.
- Write DIV=0 -> DIV reads 1; frame lasts 10 cycles. Write DIV=8 during DATA -> following bits last 8 cycles.
- Assert rst_in mid-DATA -> tx_out = 1 within the same cycle, STATUS = 0x2 after release, no further frame; a read of BASE_ADDR+0x100 gives rd_hit_out=0, rd_data_out=0.
